// File: rtl/pushbutton_poll_master.sv
// Polls a pushbutton PIO over Avalon-MM: reads edge capture, clears it if set, reads level.
// Poll takes 5 cycles (6 with an edge); no waitrequest, so every bus state is one cycle.
module pushbutton_poll_master #(
    parameter int POLL_PERIOD = 1000,
    parameter int TIMER_WIDTH = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   poll_now,
    output logic [1:0]             av_address,
    output logic                   av_chipselect,
    output logic                   av_write_n,
    output logic [31:0]            av_writedata,
    input  logic [31:0]            av_readdata,
    output logic                   busy,
    output logic                   event_pulse,
    output logic [COUNT_WIDTH-1:0] event_count,
    output logic                   button_level
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_EDGE,
        S_WAIT_EDGE,
        S_CLR,
        S_RD_LVL,
        S_WAIT_LVL,
        S_DONE
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] TIMER_RELOAD = TIMER_WIDTH'(POLL_PERIOD - 1);
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [TIMER_WIDTH-1:0] w_timer_nxt;
    logic                   r_edge_flag;
    logic                   w_edge_flag_nxt;
    logic                   r_button_level;
    logic                   w_button_level_nxt;
    logic [1:0]             r_av_address;
    logic [1:0]             w_av_address_nxt;
    logic                   r_av_chipselect;
    logic                   w_av_chipselect_nxt;
    logic                   r_av_write_n;
    logic                   w_av_write_n_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   r_event_pulse;
    logic                   w_event_pulse_nxt;
    logic [COUNT_WIDTH-1:0] r_event_count;
    logic [COUNT_WIDTH-1:0] w_event_count_nxt;
    logic                   w_unused_rdata;

    // Only bit 0 of the PIO carries information.
    assign w_unused_rdata = ^av_readdata[31:1];

    always_comb begin
        w_state_nxt        = r_state;
        w_timer_nxt        = r_timer;
        w_edge_flag_nxt    = r_edge_flag;
        w_button_level_nxt = r_button_level;
        case (r_state)
            S_IDLE: begin
                if (enable && (r_timer == '0 || poll_now)) begin
                    w_state_nxt = S_RD_EDGE;
                end else if (enable) begin
                    w_timer_nxt = r_timer - TIMER_WIDTH'(1);
                end
            end
            S_RD_EDGE:   w_state_nxt = S_WAIT_EDGE;
            S_WAIT_EDGE: begin
                w_edge_flag_nxt = av_readdata[0];
                w_state_nxt     = av_readdata[0] ? S_CLR : S_RD_LVL;
            end
            S_CLR:       w_state_nxt = S_RD_LVL;
            S_RD_LVL:    w_state_nxt = S_WAIT_LVL;
            S_WAIT_LVL: begin
                w_button_level_nxt = av_readdata[0];
                w_state_nxt        = S_DONE;
            end
            S_DONE: begin
                w_timer_nxt = TIMER_RELOAD;
                w_state_nxt = S_IDLE;
            end
            default:     w_state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        w_av_address_nxt    = ADDR_DATA;
        w_av_chipselect_nxt = 1'b0;
        w_av_write_n_nxt    = 1'b1;
        case (w_state_nxt)
            S_RD_EDGE, S_WAIT_EDGE: begin
                w_av_address_nxt    = ADDR_EDGE;
                w_av_chipselect_nxt = 1'b1;
            end
            S_CLR: begin
                w_av_address_nxt    = ADDR_EDGE;
                w_av_chipselect_nxt = 1'b1;
                w_av_write_n_nxt    = 1'b0;
            end
            S_RD_LVL, S_WAIT_LVL: begin
                w_av_chipselect_nxt = 1'b1;
            end
            default: begin
                w_av_chipselect_nxt = 1'b0;
            end
        endcase

        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_event_pulse_nxt = (w_state_nxt == S_DONE) && r_edge_flag;
        w_event_count_nxt = r_event_count;
        if (w_event_pulse_nxt) begin
            w_event_count_nxt = r_event_count + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_timer         <= TIMER_RELOAD;
            r_edge_flag     <= 1'b0;
            r_button_level  <= 1'b0;
            r_av_address    <= ADDR_DATA;
            r_av_chipselect <= 1'b0;
            r_av_write_n    <= 1'b1;
            r_busy          <= 1'b0;
            r_event_pulse   <= 1'b0;
            r_event_count   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_timer         <= w_timer_nxt;
            r_edge_flag     <= w_edge_flag_nxt;
            r_button_level  <= w_button_level_nxt;
            r_av_address    <= w_av_address_nxt;
            r_av_chipselect <= w_av_chipselect_nxt;
            r_av_write_n    <= w_av_write_n_nxt;
            r_busy          <= w_busy_nxt;
            r_event_pulse   <= w_event_pulse_nxt;
            r_event_count   <= w_event_count_nxt;
        end
    end

    assign av_address    = r_av_address;
    assign av_chipselect = r_av_chipselect;
    assign av_write_n    = r_av_write_n;
    assign av_writedata  = '0;
    assign busy          = r_busy;
    assign event_pulse   = r_event_pulse;
    assign event_count   = r_event_count;
    assign button_level  = r_button_level;

endmodule

// File: tb/tb_pushbutton_poll_master.sv
// Bench for pushbutton_poll_master with a behavioural pushbutton PIO and a press-count reference.
module tb_pushbutton_poll_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        poll_now;
    logic [1:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata = '0;
    logic        busy;
    logic        event_pulse;
    logic [1:0]  event_count;
    logic        button_level;

    logic in_port  = 1'b1;
    logic pio_prev = 1'b1;
    logic pio_edge = 1'b0;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int cyc = 0;
    int starts = 0;
    int last_start = 0;
    int start_gap = 0;
    int writes = 0;
    int pulses = 0;
    int pulse_delay = 0;
    int wd_bad = 0;
    logic prev_cs = 1'b0;

    pushbutton_poll_master #(
        .POLL_PERIOD(4),
        .TIMER_WIDTH(16),
        .COUNT_WIDTH(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .poll_now     (poll_now),
        .av_address   (av_address),
        .av_chipselect(av_chipselect),
        .av_write_n   (av_write_n),
        .av_writedata (av_writedata),
        .av_readdata  (av_readdata),
        .busy         (busy),
        .event_pulse  (event_pulse),
        .event_count  (event_count),
        .button_level (button_level)
    );

    always #5 clk = ~clk;

    // PIO responder: registered read data, falling-edge capture, clear-on-write has priority.
    always @(posedge clk) begin
        logic [31:0] junk;
        junk = $urandom;
        pio_prev <= in_port;
        if (av_chipselect && !av_write_n && av_address == 2'd3)
            pio_edge <= 1'b0;
        else if (pio_prev && !in_port)
            pio_edge <= 1'b1;
        if (av_chipselect && av_write_n) begin
            if (av_address == 2'd3)      av_readdata <= {junk[31:1], pio_edge};
            else if (av_address == 2'd0) av_readdata <= {junk[31:1], in_port};
            else                         av_readdata <= junk;
        end
    end

    // Bus monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (av_chipselect && !prev_cs && av_address == 2'd3) begin
            starts++;
            start_gap  = cyc - last_start;
            last_start = cyc;
        end
        if (av_chipselect && !av_write_n) writes++;
        if (av_writedata != 32'd0) wd_bad++;
        if (event_pulse) begin
            pulses++;
            pulse_delay = cyc - last_start;
        end
        prev_cs = av_chipselect;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 50) begin @(negedge clk); k++; end
        chk(tag, busy, 0);
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (!busy && k < 50) begin @(negedge clk); k++; end
        chk(tag, busy, 1);
    endtask

    task automatic wait_start(input string tag, input int s);
        int k = 0;
        while (starts <= s && k < 50) begin @(negedge clk); k++; end
        chk(tag, starts, s + 1);
    endtask

    task automatic press();
        @(negedge clk) in_port = 1'b0;
        repeat (2) @(negedge clk);
        in_port = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic force_poll(input string tag);
        @(negedge clk);
        enable   = 1'b1;
        poll_now = 1'b1;
        @(negedge clk);
        enable   = 1'b0;
        poll_now = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int s;
        int p0;
        int w0;
        int n;
        int fl;
        int ev;
        int ref_count;
        int wrap_exp[5];
        wrap_exp = '{1, 2, 3, 0, 1};

        reset_n  = 1'b0;
        enable   = 1'b0;
        poll_now = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_address", av_address, 0);
        chk("rst_chipselect", av_chipselect, 0);
        chk("rst_write_n", av_write_n, 1);
        chk("rst_writedata", av_writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulse", event_pulse, 0);
        chk("rst_count", event_count, 0);
        chk("rst_level", button_level, 0);
        reset_n = 1'b1;

        // Free-running polls, idle button.
        enable = 1'b1;
        k = 0;
        while (starts < 3 && k < 60) begin @(negedge clk); k++; end
        chk("idle_starts", starts, 3);
        chk("idle_gap", start_gap, 9);
        chk("idle_writes", writes, 0);
        chk("idle_count", event_count, 0);
        chk("idle_level", button_level, 1);

        // One press captured by a timer poll.
        wait_idle("pre_press_idle");
        press();
        k = 0;
        while (pulses == 0 && k < 40) begin @(negedge clk); k++; end
        chk("press_pulse", pulses, 1);
        chk("press_delay", pulse_delay, 5);
        chk("press_count", event_count, 1);
        chk("press_writes", writes, 1);
        @(negedge clk);
        chk("press_pulse_width", event_pulse, 0);
        s = starts;
        wait_start("gap_edge_start", s);
        chk("gap_edge", start_gap, 10);
        s = starts;
        wait_start("gap_clean_start", s);
        chk("gap_clean", start_gap, 9);
        wait_idle("after_clean_idle");
        chk("clean_no_event", pulses, 1);

        // Forced poll from a freshly reloaded timer; poll_now while busy ignored.
        wait_busy("stop_busy");
        enable = 1'b0;
        wait_idle("stop_idle");
        @(negedge clk);
        enable   = 1'b1;
        poll_now = 1'b1;
        s = starts;
        @(negedge clk);
        poll_now = 1'b0;
        chk("force_busy", busy, 1);
        chk("force_addr", av_address, 3);
        chk("force_cs", av_chipselect, 1);
        chk("force_started", starts, s + 1);
        s = starts;
        @(negedge clk) poll_now = 1'b1;
        @(negedge clk) poll_now = 1'b0;
        wait_start("force_next_start", s);
        chk("force_reload_gap", start_gap, 9);
        enable = 1'b0;
        wait_idle("force_stop_idle");

        // Three presses between polls give one event.
        p0 = pulses;
        w0 = writes;
        repeat (3) press();
        force_poll("triple_idle");
        chk("triple_count", event_count, 2);
        chk("triple_pulses", pulses - p0, 1);
        chk("triple_writes", writes - w0, 1);

        // Randomized press batches against a press-count reference.
        ref_count = 2;
        for (int it = 0; it < 10; it++) begin
            n  = $urandom_range(0, 3);
            fl = $urandom_range(0, 1);
            repeat (n) press();
            if (fl != 0) begin
                @(negedge clk) in_port = 1'b0;
                repeat (2) @(negedge clk);
            end
            p0 = pulses;
            w0 = writes;
            force_poll("rand_idle");
            ev = ((n + fl) > 0) ? 1 : 0;
            ref_count = (ref_count + ev) % 4;
            chk("rand_count", event_count, ref_count);
            chk("rand_pulses", pulses - p0, ev);
            chk("rand_writes", writes - w0, ev);
            chk("rand_level", button_level, (fl != 0) ? 0 : 1);
            @(negedge clk) in_port = 1'b1;
            repeat (2) @(negedge clk);
        end

        // Reset asserted during the clear write.
        press();
        @(negedge clk);
        enable   = 1'b1;
        poll_now = 1'b1;
        @(negedge clk);
        enable   = 1'b0;
        poll_now = 1'b0;
        k = 0;
        while (av_write_n && k < 20) begin @(negedge clk); k++; end
        chk("clr_write_n", av_write_n, 0);
        chk("clr_addr", av_address, 3);
        reset_n = 1'b0;
        #1;
        chk("arst_write_n", av_write_n, 1);
        chk("arst_cs", av_chipselect, 0);
        chk("arst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        w0 = writes;
        s  = starts;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_count", event_count, 0);
        chk("post_rst_pio_edge", pio_edge, 1);
        chk("post_rst_writes", writes, w0);
        chk("post_rst_starts", starts, s);

        // Counter wrap with a 2-bit count; first poll collects the surviving edge.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) press();
            force_poll("wrap_idle");
            chk("wrap_count", event_count, wrap_exp[i]);
        end
        chk("writedata_zero", wd_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
